cw_envelope: RTL and testbench

CW_ENVELOPE -- requirements
Module: cw_envelope

---
 rtl/cw_envelope_pkg.sv | 38 +++
 rtl/cw_envelope_shape_rom.sv | 28 ++
 rtl/cw_envelope.sv | 140 ++++++++++++++
 tb/tb_cw_envelope.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cw_envelope_pkg.sv
// Shared constants, FSM encoding and shape generator for the CW keying envelope.
package cw_envelope_pkg;

    localparam int unsigned RAMP_STEPS_DEF = 256;
    localparam int unsigned DEBOUNCE_DEF   = 4;
    localparam int unsigned HANG_TICKS_DEF = 1000;

    localparam int unsigned SHAPE_W = 16;
    localparam int unsigned LEVEL_W = 8;
    localparam int unsigned PROD_W  = 25;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ATTACK,
        ST_ON,
        ST_RELEASE,
        ST_HANG
    } cw_state_e;

    // Raised cosine as sin^2 over a quarter period, sin via Bhaskara's rational form.
    // Integer-only so it folds at elaboration; exact 0 and 65535 at the ends, monotonic.
    function automatic logic [SHAPE_W-1:0] raised_cos(int unsigned i, int unsigned steps);
        longint d;
        longint a;
        longint b;
        longint num;
        longint den;
        longint s_q;
        d   = 2 * (longint'(steps) - 1);
        a   = longint'(i);
        b   = d - a;
        num = 16 * a * b;
        den = 5 * d * d - 4 * a * b;
        s_q = (num << 16) / den;
        return SHAPE_W'((s_q * s_q * 65535) >> 32);
    endfunction

endpackage

// File: rtl/cw_envelope_shape_rom.sv
// Registered raised-cosine shape table indexed by the ramp position.
module cw_shape_rom
    import cw_envelope_pkg::*;
#(
    parameter int unsigned RAMP_STEPS = RAMP_STEPS_DEF,
    parameter int unsigned IDX_W      = $clog2(RAMP_STEPS)
) (
    input  logic               clock_100k,
    input  logic               reset,
    input  logic [IDX_W-1:0]   idx,
    output logic [SHAPE_W-1:0] shape
);

    logic [SHAPE_W-1:0] shape_tab [RAMP_STEPS];

    for (genvar i = 0; i < RAMP_STEPS; i++) begin : g_tab
        assign shape_tab[i] = raised_cos(i, RAMP_STEPS);
    end

    always_ff @(posedge clock_100k) begin
        if (reset) begin
            shape <= '0;
        end else begin
            shape <= shape_tab[idx];
        end
    end

endmodule

// File: rtl/cw_envelope.sv
// CW key conditioning and shaped transmit envelope: sync, debounce, ramp FSM,
// shape lookup and level scaling.
module cw_envelope
    import cw_envelope_pkg::*;
#(
    parameter int unsigned RAMP_STEPS = RAMP_STEPS_DEF,
    parameter int unsigned DEBOUNCE   = DEBOUNCE_DEF,
    parameter int unsigned HANG_TICKS = HANG_TICKS_DEF
) (
    input  logic               clock_100k,
    input  logic               reset,
    input  logic               CW,
    input  logic [LEVEL_W-1:0] tx_level,
    output logic [SHAPE_W-1:0] envelope,
    output logic               tx_enable,
    output logic               keyed
);

    localparam int unsigned IDX_W  = $clog2(RAMP_STEPS);
    localparam int unsigned DEB_W  = $clog2(DEBOUNCE + 1);
    localparam int unsigned HANG_W = $clog2(HANG_TICKS + 1);

    localparam logic [IDX_W-1:0]  IDX_MAX   = IDX_W'(RAMP_STEPS - 1);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE - 1);
    localparam logic [HANG_W-1:0] HANG_LOAD = HANG_W'(HANG_TICKS - 1);

    logic              cw_meta;
    logic              cw_s;
    logic [DEB_W-1:0]  deb_cnt;

    cw_state_e         state;
    cw_state_e         state_d;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  idx_d;
    logic [HANG_W-1:0] hang_cnt;
    logic [HANG_W-1:0] hang_cnt_d;

    logic [SHAPE_W-1:0] shape_q;
    logic [PROD_W-1:0]  product_c;
    logic               prod_unused_c;

    // Two-flop synchronizer, then a run-length debounce against the current key state.
    always_ff @(posedge clock_100k) begin
        if (reset) begin
            cw_meta <= 1'b0;
            cw_s    <= 1'b0;
            deb_cnt <= '0;
            keyed   <= 1'b0;
        end else begin
            cw_meta <= CW;
            cw_s    <= cw_meta;
            if (cw_s == keyed) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
                deb_cnt <= '0;
                keyed   <= cw_s;
            end else begin
                deb_cnt <= deb_cnt + DEB_W'(1);
            end
        end
    end

    // tx_enable follows the next state so it rises and falls on the transition edge.
    always_ff @(posedge clock_100k) begin
        if (reset) begin
            state     <= ST_IDLE;
            idx       <= '0;
            hang_cnt  <= '0;
            tx_enable <= 1'b0;
        end else begin
            state     <= state_d;
            idx       <= idx_d;
            hang_cnt  <= hang_cnt_d;
            tx_enable <= (state_d != ST_IDLE);
        end
    end

    always_comb begin
        state_d    = state;
        idx_d      = idx;
        hang_cnt_d = hang_cnt;
        unique case (state)
            ST_IDLE: begin
                idx_d = '0;
                if (keyed) state_d = ST_ATTACK;
            end
            ST_ATTACK: begin
                if (idx == IDX_MAX)  state_d = ST_ON;
                else if (!keyed)     state_d = ST_RELEASE;
                else                 idx_d   = idx + IDX_W'(1);
            end
            ST_ON: begin
                idx_d = IDX_MAX;
                if (!keyed) state_d = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (keyed) begin
                    state_d = ST_ATTACK;
                end else if (idx == '0) begin
                    state_d    = ST_HANG;
                    hang_cnt_d = HANG_LOAD;
                end else begin
                    idx_d = idx - IDX_W'(1);
                end
            end
            ST_HANG: begin
                if (keyed)                 state_d    = ST_ATTACK;
                else if (hang_cnt == '0)   state_d    = ST_IDLE;
                else                       hang_cnt_d = hang_cnt - HANG_W'(1);
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    cw_shape_rom #(
        .RAMP_STEPS (RAMP_STEPS),
        .IDX_W      (IDX_W)
    ) u_shape_rom (
        .clock_100k (clock_100k),
        .reset      (reset),
        .idx        (idx),
        .shape      (shape_q)
    );

    // Scale by (tx_level + 1) so 255 maps to exactly x256 before the >>8.
    assign product_c     = PROD_W'(shape_q) * (PROD_W'(tx_level) + PROD_W'(1));
    assign prod_unused_c = ^{product_c[PROD_W-1], product_c[LEVEL_W-1:0]};

    always_ff @(posedge clock_100k) begin
        if (reset) begin
            envelope <= '0;
        end else begin
            envelope <= product_c[LEVEL_W +: SHAPE_W];
        end
    end

endmodule

// File: tb/tb_cw_envelope.sv
// Directed and randomized bench for cw_envelope against a cycle-level behavioural model.
module tb_cw_envelope;

    localparam int  RS  = 8;
    localparam int  DB  = 4;
    localparam int  HT  = 10;
    localparam int  TOL = 400;
    localparam real PI  = 3.14159265358979;

    localparam int M_IDLE = 0, M_ATTACK = 1, M_ON = 2, M_RELEASE = 3, M_HANG = 4;

    logic        clock_100k = 1'b0;
    logic        reset      = 1'b1;
    logic        CW         = 1'b0;
    logic [7:0]  tx_level   = 8'd255;
    logic [15:0] envelope;
    logic        tx_enable;
    logic        keyed;

    cw_envelope #(
        .RAMP_STEPS (RS),
        .DEBOUNCE   (DB),
        .HANG_TICKS (HT)
    ) dut (
        .clock_100k (clock_100k),
        .reset      (reset),
        .CW         (CW),
        .tx_level   (tx_level),
        .envelope   (envelope),
        .tx_enable  (tx_enable),
        .keyed      (keyed)
    );

    always #5 clock_100k = ~clock_100k;

    int n_assert = 0;
    int n_fail   = 0;

    // Model state: sync pipe, disagreement run length, ramp mode/position, pipeline taps.
    int m_meta, m_sync, m_keyed, m_run;
    int m_mode, m_idx, m_hang, m_tx;
    int m_rom_idx, m_env_idx, m_env_lvl;
    int m_hang_entered;

    int   t, peak, prev, hold;
    logic seen, mono, falling, txlow;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_near(string tag, logic [31:0] obs, int exp, int tol);
        int diff;
        diff = int'(obs) - exp;
        n_assert++;
        assert (!$isunknown(obs) && diff <= tol && diff >= -tol)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d +/- %0d", tag, obs, exp, tol);
        end
    endtask

    // Ideal raised-cosine envelope for a ramp position and level.
    function automatic int expected_env(int i, int lvl);
        real s;
        if (i == 0) return 0;
        if (i == RS - 1) return (65535 * (lvl + 1)) >>> 8;
        s = 65535.0 * (1.0 - $cos(PI * i / (RS - 1))) / 2.0;
        return int'($floor(s * (lvl + 1) / 256.0));
    endfunction

    task automatic model_step();
        int n_keyed, n_run, n_mode, n_idx, n_hang;
        if (reset) begin
            m_meta = 0; m_sync = 0; m_keyed = 0; m_run = 0;
            m_mode = M_IDLE; m_idx = 0; m_hang = 0; m_tx = 0;
            m_rom_idx = 0; m_env_idx = 0; m_env_lvl = 0; m_hang_entered = 0;
            return;
        end
        n_keyed = m_keyed;
        n_run   = 0;
        if (m_sync != m_keyed) begin
            n_run = m_run + 1;
            if (n_run == DB) begin
                n_keyed = m_sync;
                n_run   = 0;
            end
        end
        n_mode = m_mode; n_idx = m_idx; n_hang = m_hang;
        case (m_mode)
            M_IDLE:    begin n_idx = 0; if (m_keyed != 0) n_mode = M_ATTACK; end
            M_ATTACK:  if (m_idx == RS - 1) n_mode = M_ON;
                       else if (m_keyed == 0) n_mode = M_RELEASE;
                       else n_idx = m_idx + 1;
            M_ON:      if (m_keyed == 0) n_mode = M_RELEASE;
            M_RELEASE: if (m_keyed != 0) n_mode = M_ATTACK;
                       else if (m_idx == 0) begin n_mode = M_HANG; n_hang = HT - 1; end
                       else n_idx = m_idx - 1;
            default:   if (m_keyed != 0) n_mode = M_ATTACK;
                       else if (m_hang == 0) n_mode = M_IDLE;
                       else n_hang = m_hang - 1;
        endcase
        m_env_idx      = m_rom_idx;
        m_env_lvl      = int'(tx_level);
        m_rom_idx      = m_idx;
        m_sync         = m_meta;
        m_meta         = int'(CW);
        m_keyed        = n_keyed;
        m_run          = n_run;
        m_hang_entered = (n_mode == M_HANG && m_mode != M_HANG) ? 1 : 0;
        m_mode         = n_mode;
        m_idx          = n_idx;
        m_hang         = n_hang;
        m_tx           = (n_mode != M_IDLE) ? 1 : 0;
    endtask

    task automatic tick();
        int e;
        @(posedge clock_100k);
        model_step();
        #1;
        check("keyed", 32'(keyed), m_keyed);
        check("tx_enable", 32'(tx_enable), m_tx);
        e = expected_env(m_env_idx, m_env_lvl);
        if (m_env_idx == 0 || m_env_idx == RS - 1) check("envelope", 32'(envelope), e);
        else check_near("envelope_ramp", 32'(envelope), e, TOL);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: observed timeout, expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        repeat (3) tick();
        check("reset_env", 32'(envelope), 0);
        check("reset_tx", 32'(tx_enable), 0);
        check("reset_keyed", 32'(keyed), 0);
        reset = 1'b0;
        repeat (4) tick();

        // Key tap shorter than the debounce window
        seen = 1'b0;
        CW = 1'b1;
        repeat (3) begin tick(); seen = seen | keyed | tx_enable | (envelope != 16'd0); end
        CW = 1'b0;
        repeat (12) begin tick(); seen = seen | keyed | tx_enable | (envelope != 16'd0); end
        check("tap_quiet", 32'(seen), 0);

        // Full dot: key latency, full-scale latency, hang timing
        CW = 1'b1;
        t = 0;
        while (keyed !== 1'b1 && t < 20) begin tick(); t++; end
        check("dot_key_latency", t, 2 + DB);
        t = 0;
        while (envelope !== 16'hFFFF && t < 40) begin tick(); t++; end
        // ATTACK entry edge, RS-1 increments, then ROM and product registers
        check("dot_full_scale_latency", t, RS + 2);
        repeat (24) tick();
        CW = 1'b0;
        t = 0;
        while (m_hang_entered == 0 && t < 40) begin tick(); t++; end
        tick();
        check("hang_env_zero", 32'(envelope), 0);
        t = 1;
        while (tx_enable !== 1'b0 && t < 30) begin tick(); t++; end
        check("hang_tx_fall", t, HT);
        repeat (3) tick();

        // Mid-attack release: a 4-clock key releases the ramp at idx 3
        CW = 1'b1;
        repeat (4) tick();
        CW = 1'b0;
        peak = 0; prev = 0; mono = 1'b1; falling = 1'b0;
        repeat (20) begin
            tick();
            if (int'(envelope) < prev) falling = 1'b1;
            else if (falling && int'(envelope) > prev) mono = 1'b0;
            if (int'(envelope) > peak) peak = int'(envelope);
            prev = int'(envelope);
        end
        check_near("midatk_peak", 32'(peak), expected_env(3, 255), TOL);
        check("midatk_monotonic", 32'(mono), 1);
        t = 0;
        while (tx_enable !== 1'b0 && t < 30) begin tick(); t++; end
        repeat (3) tick();

        // Re-key so that keyed returns five clocks into HANG
        CW = 1'b1;
        t = 0;
        while (keyed !== 1'b1 && t < 20) begin tick(); t++; end
        repeat (12) tick();
        CW = 1'b0;
        t = 0;
        while (!(m_mode == M_RELEASE && m_idx == 1) && t < 60) begin tick(); t++; end
        CW = 1'b1;
        txlow = 1'b0;
        repeat (25) begin tick(); if (tx_enable !== 1'b1) txlow = 1'b1; end
        check("rekey_tx_held", 32'(txlow), 0);
        check("rekey_full", 32'(envelope), 65535);

        // Level change at ON, then reset during ON with the key still down
        tx_level = 8'd127;
        repeat (2) tick();
        check("scale_127", 32'(envelope), 32767);
        reset = 1'b1;
        tick();
        check("rst_env", 32'(envelope), 0);
        check("rst_tx", 32'(tx_enable), 0);
        check("rst_keyed", 32'(keyed), 0);
        reset = 1'b0;
        t = 0;
        while (keyed !== 1'b1 && t < 20) begin tick(); t++; end
        check("rst_rekey_latency", t, 2 + DB);
        tx_level = 8'd255;
        CW = 1'b0;
        t = 0;
        while (tx_enable !== 1'b0 && t < 60) begin tick(); t++; end

        // Randomized key patterns, level changes and occasional resets
        for (int seg = 0; seg < 120; seg++) begin
            CW = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) tx_level = 8'($urandom_range(0, 255));
            reset = ($urandom_range(0, 40) == 0);
            hold = int'($urandom_range(1, 25));
            repeat (hold) begin tick(); reset = 1'b0; end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
